// File: rtl/gray_rank_filter_3x3_if.sv
// Pixel-stream bundle between the grey source and the 3x3 rank filter.
// master = upstream source/consumer side, slave = filter side.
interface gray_rank_filter_3x3_if #(
    parameter int DATA_WIDTH = 8
);
    logic [1:0]            mode;
    logic                  gray_valid;
    logic                  gray_hsync;
    logic                  gray_vsync;
    logic [DATA_WIDTH-1:0] gray;
    logic                  filt_valid;
    logic                  filt_hsync;
    logic                  filt_vsync;
    logic [DATA_WIDTH-1:0] filt_out;
    logic                  line_err;

    modport master (
        output mode, gray_valid, gray_hsync, gray_vsync, gray,
        input  filt_valid, filt_hsync, filt_vsync, filt_out, line_err
    );

    modport slave (
        input  mode, gray_valid, gray_hsync, gray_vsync, gray,
        output filt_valid, filt_hsync, filt_vsync, filt_out, line_err
    );
endinterface

// File: rtl/gray_rank_filter_3x3.sv
// 3x3 rank filter (median/min/max/bypass) with internal two-line buffer, 4-cycle latency.
// Build option: define BORDER_PASS_EN to pass the window centre on border pixels instead of 0.
module gray_rank_filter_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int COL_W      = 10
) (
    input  logic                   clk,
    input  logic                   rst_p,
    gray_rank_filter_3x3_if.slave  bus
);
    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    typedef logic signed [DATA_WIDTH:0] unused_t;
    typedef logic [DATA_WIDTH-1:0] pix_t;

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        return max2(max2(a, b), c);
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        return min2(min2(a, b), c);
    endfunction

    function automatic pix_t mid3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    function automatic logic [COL_W-1:0] sat_inc(input logic [COL_W-1:0] v);
        return (v == '1) ? v : v + COL_W'(1);
    endfunction

    // Line buffers: no reset, contents are don't-care until written this frame.
    pix_t lb1_mem [IMG_WIDTH];
    pix_t lb2_mem [IMG_WIDTH];

    logic             hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic             seen_low_q, seen_low_d, synced_q, synced_d;
    logic             line_full_q, line_full_d, line_err_q, line_err_d;
    logic [1:0]       mode_q, mode_d;
    logic [COL_W-1:0] col_q, col_d, row_q, row_d;

    pix_t win_p0_q [3][3];
    pix_t win_p0_d [3][3];
    logic brd_p0_q, brd_p0_d, ovf_p0_q, ovf_p0_d;
    logic vld_p0_q, vld_p0_d, hs_p0_q, hs_p0_d, vs_p0_q, vs_p0_d;

    pix_t mx_p1_q [3];
    pix_t mx_p1_d [3];
    pix_t md_p1_q [3];
    pix_t md_p1_d [3];
    pix_t mn_p1_q [3];
    pix_t mn_p1_d [3];
    pix_t ctr_p1_q, ctr_p1_d;
    logic brd_p1_q, brd_p1_d, ovf_p1_q, ovf_p1_d;
    logic vld_p1_q, vld_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;

    pix_t mnmx_p2_q, mnmx_p2_d, mdmd_p2_q, mdmd_p2_d, mxmn_p2_q, mxmn_p2_d;
    pix_t mnmn_p2_q, mnmn_p2_d, mxmx_p2_q, mxmx_p2_d, ctr_p2_q, ctr_p2_d;
    logic brd_p2_q, brd_p2_d, ovf_p2_q, ovf_p2_d;
    logic vld_p2_q, vld_p2_d, hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;

    pix_t filt_out_q, filt_out_d;
    logic filt_valid_q, filt_valid_d, filt_hsync_q, filt_hsync_d, filt_vsync_q, filt_vsync_d;

    logic          vs_rise, hs_fall, accept, lb_we, ovf_pix;
    logic [AW-1:0] addr;
    pix_t          lb1_rd, lb2_rd, tap1, tap2, brd_val, median;

    // A rising edge only counts once vsync has been seen low, so a mid-frame reset waits for the next frame.
    assign vs_rise = bus.gray_vsync && !vs_prev_q && seen_low_q;
    assign hs_fall = !bus.gray_hsync && hs_prev_q;
    assign accept  = bus.gray_valid && bus.gray_hsync && bus.gray_vsync && (synced_q || vs_rise);
    assign lb_we   = accept && !line_full_q;
    assign ovf_pix = accept && line_full_q;
    assign addr    = col_q[AW-1:0];
    assign lb1_rd  = lb1_mem[addr];
    assign lb2_rd  = lb2_mem[addr];
    // Rows above the frame top read as the cleared-window value, not stale RAM.
    assign tap1    = (row_q == '0) ? '0 : lb1_rd;
    assign tap2    = (row_q < COL_W'(2)) ? '0 : lb2_rd;
    assign median  = mid3(mnmx_p2_q, mdmd_p2_q, mxmn_p2_q);

`ifdef BORDER_PASS_EN
    assign brd_val = ctr_p2_q;
`else
    assign brd_val = '0;
`endif

    always_comb begin
        hs_prev_d   = bus.gray_hsync;
        vs_prev_d   = bus.gray_vsync;
        seen_low_d  = seen_low_q | !bus.gray_vsync;
        synced_d    = synced_q | vs_rise;
        mode_d      = vs_rise ? bus.mode : mode_q;
        col_d       = col_q;
        line_full_d = line_full_q;
        row_d       = row_q;
        line_err_d  = line_err_q;

        if (hs_fall) begin
            col_d       = '0;
            line_full_d = 1'b0;
        end else if (lb_we) begin
            if (col_q == LAST_COL) line_full_d = 1'b1;
            else                   col_d = col_q + COL_W'(1);
        end

        if (vs_rise)
            row_d = '0;
        else if (hs_fall && bus.gray_vsync && (col_q != '0 || line_full_q))
            row_d = sat_inc(row_q);

        if (vs_rise) line_err_d = 1'b0;
        if (ovf_pix) line_err_d = 1'b1;

        // S1: window update; row 0 = two lines up, column 0 = newest pixel
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                win_p0_d[i][j] = win_p0_q[i][j];
        if (!bus.gray_hsync || !bus.gray_vsync) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    win_p0_d[i][j] = '0;
        end else if (lb_we) begin
            for (int i = 0; i < 3; i++) begin
                win_p0_d[i][2] = win_p0_q[i][1];
                win_p0_d[i][1] = win_p0_q[i][0];
            end
            win_p0_d[0][0] = tap2;
            win_p0_d[1][0] = tap1;
            win_p0_d[2][0] = bus.gray;
        end
        brd_p0_d = (row_q < COL_W'(2)) || (col_q < COL_W'(2));
        ovf_p0_d = ovf_pix;
        vld_p0_d = bus.gray_valid;
        hs_p0_d  = bus.gray_hsync;
        vs_p0_d  = bus.gray_vsync;

        // S2: per-row sort
        for (int i = 0; i < 3; i++) begin
            mx_p1_d[i] = max3(win_p0_q[i][0], win_p0_q[i][1], win_p0_q[i][2]);
            md_p1_d[i] = mid3(win_p0_q[i][0], win_p0_q[i][1], win_p0_q[i][2]);
            mn_p1_d[i] = min3(win_p0_q[i][0], win_p0_q[i][1], win_p0_q[i][2]);
        end
        ctr_p1_d = win_p0_q[1][1];
        brd_p1_d = brd_p0_q;
        ovf_p1_d = ovf_p0_q;
        vld_p1_d = vld_p0_q;
        hs_p1_d  = hs_p0_q;
        vs_p1_d  = vs_p0_q;

        // S3: per-column sort of the row results
        mnmx_p2_d = min3(mx_p1_q[0], mx_p1_q[1], mx_p1_q[2]);
        mdmd_p2_d = mid3(md_p1_q[0], md_p1_q[1], md_p1_q[2]);
        mxmn_p2_d = max3(mn_p1_q[0], mn_p1_q[1], mn_p1_q[2]);
        mnmn_p2_d = min3(mn_p1_q[0], mn_p1_q[1], mn_p1_q[2]);
        mxmx_p2_d = max3(mx_p1_q[0], mx_p1_q[1], mx_p1_q[2]);
        ctr_p2_d  = ctr_p1_q;
        brd_p2_d  = brd_p1_q;
        ovf_p2_d  = ovf_p1_q;
        vld_p2_d  = vld_p1_q;
        hs_p2_d   = hs_p1_q;
        vs_p2_d   = vs_p1_q;

        // S4: rank select and border/overflow override
        if (ovf_p2_q)
            filt_out_d = '0;
        else if (brd_p2_q)
            filt_out_d = brd_val;
        else begin
            case (mode_q)
                2'b00:   filt_out_d = median;
                2'b01:   filt_out_d = mnmn_p2_q;
                2'b10:   filt_out_d = mxmx_p2_q;
                default: filt_out_d = ctr_p2_q;
            endcase
        end
        filt_valid_d = vld_p2_q;
        filt_hsync_d = hs_p2_q;
        filt_vsync_d = vs_p2_q;
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb1_mem[addr] <= bus.gray;
            lb2_mem[addr] <= lb1_rd;
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            seen_low_q  <= 1'b0;
            synced_q    <= 1'b0;
            line_full_q <= 1'b0;
            line_err_q  <= 1'b0;
            mode_q      <= 2'b00;
            col_q       <= '0;
            row_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) win_p0_q[i][j] <= '0;
                mx_p1_q[i] <= '0;
                md_p1_q[i] <= '0;
                mn_p1_q[i] <= '0;
            end
            {brd_p0_q, ovf_p0_q, vld_p0_q, hs_p0_q, vs_p0_q} <= '0;
            {brd_p1_q, ovf_p1_q, vld_p1_q, hs_p1_q, vs_p1_q} <= '0;
            {brd_p2_q, ovf_p2_q, vld_p2_q, hs_p2_q, vs_p2_q} <= '0;
            ctr_p1_q     <= '0;
            mnmx_p2_q    <= '0;
            mdmd_p2_q    <= '0;
            mxmn_p2_q    <= '0;
            mnmn_p2_q    <= '0;
            mxmx_p2_q    <= '0;
            ctr_p2_q     <= '0;
            filt_out_q   <= '0;
            filt_valid_q <= 1'b0;
            filt_hsync_q <= 1'b0;
            filt_vsync_q <= 1'b0;
        end else begin
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            seen_low_q  <= seen_low_d;
            synced_q    <= synced_d;
            line_full_q <= line_full_d;
            line_err_q  <= line_err_d;
            mode_q      <= mode_d;
            col_q       <= col_d;
            row_q       <= row_d;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) win_p0_q[i][j] <= win_p0_d[i][j];
                mx_p1_q[i] <= mx_p1_d[i];
                md_p1_q[i] <= md_p1_d[i];
                mn_p1_q[i] <= mn_p1_d[i];
            end
            {brd_p0_q, ovf_p0_q, vld_p0_q, hs_p0_q, vs_p0_q} <= {brd_p0_d, ovf_p0_d, vld_p0_d, hs_p0_d, vs_p0_d};
            {brd_p1_q, ovf_p1_q, vld_p1_q, hs_p1_q, vs_p1_q} <= {brd_p1_d, ovf_p1_d, vld_p1_d, hs_p1_d, vs_p1_d};
            {brd_p2_q, ovf_p2_q, vld_p2_q, hs_p2_q, vs_p2_q} <= {brd_p2_d, ovf_p2_d, vld_p2_d, hs_p2_d, vs_p2_d};
            ctr_p1_q     <= ctr_p1_d;
            mnmx_p2_q    <= mnmx_p2_d;
            mdmd_p2_q    <= mdmd_p2_d;
            mxmn_p2_q    <= mxmn_p2_d;
            mnmn_p2_q    <= mnmn_p2_d;
            mxmx_p2_q    <= mxmx_p2_d;
            ctr_p2_q     <= ctr_p2_d;
            filt_out_q   <= filt_out_d;
            filt_valid_q <= filt_valid_d;
            filt_hsync_q <= filt_hsync_d;
            filt_vsync_q <= filt_vsync_d;
        end
    end

    assign bus.filt_valid = filt_valid_q;
    assign bus.filt_hsync = filt_hsync_q;
    assign bus.filt_vsync = filt_vsync_q;
    assign bus.filt_out   = filt_out_q;
    assign bus.line_err   = line_err_q;
endmodule

// File: tb/tb_gray_rank_filter_3x3.sv
// Bench for gray_rank_filter_3x3: 8x8 frames driven tick by tick, outputs compared against
// a frame-level rank-filter model (sorting the 3x3 neighbourhood directly).
module tb_gray_rank_filter_3x3;
    localparam int IMGW = 8;
    localparam int ROWS = 8;

    logic clk = 1'b0;
    logic rst_p = 1'b1;
    always #5 clk = ~clk;

    gray_rank_filter_3x3_if #(.DATA_WIDTH(8)) bus();

    gray_rank_filter_3x3 #(.DATA_WIDTH(8), .IMG_WIDTH(IMGW), .COL_W(4)) dut (
        .clk   (clk),
        .rst_p (rst_p),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic       v;
        logic       h;
        logic       s;
        logic [7:0] d;
    } exp_t;

    exp_t       q[$];
    logic [7:0] img [ROWS][10];
    int         checks = 0;
    int         errors = 0;
    bit         chk_en = 1'b0;
    bit         lerr = 1'b0;
    bit         tb_vs_prev = 1'b0;
    int         cur_r = 0;
    int         cur_c = 0;
    logic [1:0] frame_mode = 2'b00;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    // Reference: rank of the 3x3 neighbourhood ending at (r,c).
    function automatic logic [7:0] model(input int r, input int c, input logic [1:0] m);
        logic [7:0] v [9];
        logic [7:0] t;
        int n;
        if (c >= IMGW) return 8'h00;
        if (r < 2 || c < 2) begin
`ifdef BORDER_PASS_EN
            if (r >= 1 && c >= 1) return img[r-1][c-1];
`endif
            return 8'h00;
        end
        if (m == 2'b11) return img[r-1][c-1];
        n = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
                v[n] = img[r-dr][c-dc];
                n++;
            end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (v[j] > v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        case (m)
            2'b00:   return v[4];
            2'b01:   return v[0];
            default: return v[8];
        endcase
    endfunction

    task automatic tick();
        exp_t e;
        exp_t o;
        logic acc;
        @(posedge clk);
        @(negedge clk);
        if (chk_en) begin
            acc = bus.gray_valid && bus.gray_hsync && bus.gray_vsync;
            e.v = bus.gray_valid;
            e.h = bus.gray_hsync;
            e.s = bus.gray_vsync;
            e.d = acc ? model(cur_r, cur_c, frame_mode) : 8'h00;
            if (bus.gray_vsync && !tb_vs_prev) lerr = 1'b0;
            if (acc && cur_c >= IMGW) lerr = 1'b1;
            q.push_back(e);
            if (q.size() > 3) begin
                o = q.pop_front();
                chk("filt_valid", 32'(bus.filt_valid), 32'(o.v));
                chk("filt_hsync", 32'(bus.filt_hsync), 32'(o.h));
                chk("filt_vsync", 32'(bus.filt_vsync), 32'(o.s));
                if (o.v) chk("filt_out", 32'(bus.filt_out), 32'(o.d));
            end
            chk("line_err", 32'(bus.line_err), 32'(lerr));
        end
        tb_vs_prev = bus.gray_vsync;
    endtask

    task automatic prime_queue();
        q.delete();
        repeat (3) q.push_back(exp_t'(0));
        lerr   = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.filt_valid), 32'd0);
        chk({tag, "_hsync"}, 32'(bus.filt_hsync), 32'd0);
        chk({tag, "_vsync"}, 32'(bus.filt_vsync), 32'd0);
        chk({tag, "_out"},   32'(bus.filt_out),   32'd0);
        chk({tag, "_lerr"},  32'(bus.line_err),   32'd0);
    endtask

    task automatic pulse_reset();
        #2 rst_p = 1'b1;
        #1 check_outputs_zero("rst_async");
        chk_en = 1'b0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_p = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] fmode, input bit gaps, input int long_row, input int rst_row);
        int n;
        frame_mode     = fmode;
        bus.mode       = fmode;
        bus.gray_vsync = 1'b1;
        bus.gray_hsync = 1'b0;
        bus.gray_valid = 1'b0;
        tick();
        if (gaps) bus.mode = ~fmode;
        for (int r = 0; r < ROWS; r++) begin
            cur_r = r;
            bus.gray_hsync = 1'b0;
            tick();
            tick();
            bus.gray_hsync = 1'b1;
            n = (r == long_row) ? 10 : IMGW;
            for (int c = 0; c < n; c++) begin
                if (r == rst_row && c == 3) pulse_reset();
                if (gaps && (c % 3 == 1)) begin
                    bus.gray_valid = 1'b0;
                    repeat (3) tick();
                end
                if (gaps && r == 5 && c == 2) bus.mode = $urandom_range(0, 3);
                cur_c = c;
                bus.gray = img[r][c];
                bus.gray_valid = 1'b1;
                tick();
            end
            bus.gray_valid = 1'b0;
            tick();
        end
        bus.gray_hsync = 1'b0;
        tick();
        bus.gray_vsync = 1'b0;
        repeat (6) tick();
        if (!chk_en) prime_queue();
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 10; c++)
                img[r][c] = 8'($urandom);
    endtask

    initial begin
        bus.mode       = 2'b00;
        bus.gray_valid = 1'b0;
        bus.gray_hsync = 1'b0;
        bus.gray_vsync = 1'b0;
        bus.gray       = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst_p = 1'b0;
        prime_queue();
        repeat (4) tick();

        // Constant field: border zero, interior 0x55.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 10; c++) img[r][c] = 8'h55;
        send_frame(2'b00, 1'b0, -1, -1);

        // Single hot pixel: median removes it, max spreads it.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 10; c++) img[r][c] = 8'h40;
        img[4][4] = 8'hFF;
        send_frame(2'b00, 1'b0, -1, -1);
        send_frame(2'b10, 1'b0, -1, -1);

        // Ramp: min/max pick opposite window corners.
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < 10; c++) img[r][c] = 8'(8 * r + c);
        send_frame(2'b01, 1'b0, -1, -1);
        send_frame(2'b10, 1'b0, -1, -1);

        // Valid gaps and mid-frame mode changes, then the next frame's mode.
        fill_random();
        send_frame(2'b00, 1'b1, -1, -1);
        send_frame(2'b01, 1'b0, -1, -1);
        send_frame(2'b11, 1'b1, -1, -1);

        // Over-long line sets line_err; next frame clears it.
        fill_random();
        send_frame(2'b10, 1'b0, 3, -1);
        send_frame(2'b00, 1'b0, -1, -1);

        // Asynchronous reset in row 4, then a golden frame.
        fill_random();
        send_frame(2'b01, 1'b0, -1, 4);
        fill_random();
        send_frame(2'b00, 1'b0, -1, -1);

        for (int k = 0; k < 4; k++) begin
            fill_random();
            send_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
